frame_beat_tx: RTL and testbench

Frame transmitter for the FFT output path: accepts one complete 512-sample I/Q frame in parallel on a load strobe, then sends it downstream as 16 beats of 32 lanes under a valid/ready handshake. It sits after the bit-reversal reorder stage and drives its `done` pulse and 512-entry output arrays back out onto a narrow, flow-controlled beat bus. The beat bus uses the same 32-lane, 13-bit beat format that feeds the reorder stage.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/frame_bank.sv | 36 +++
 rtl/frame_beat_tx.sv | 120 ++++++++++++
 tb/tb_frame_beat_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared frame/beat geometry, sample type and bank states for the FFT output path
package fft_pkg;

  localparam int DATA_WIDTH = 13;
  localparam int FRAME      = 512;
  localparam int LANES      = 32;
  localparam int BEATS      = FRAME / LANES;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int LANE_W     = $clog2(LANES);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SEND  = 2'd2
  } bank_state_t;

  // True on the final beat of a frame.
  function automatic logic is_last_beat(input logic [BEAT_W-1:0] idx);
    return idx == BEAT_W'(BEATS - 1);
  endfunction

endpackage

// File: rtl/frame_bank.sv
// rtl/frame_bank.sv - one I/Q frame storage bank with parallel load and beat-select read mux
module frame_bank
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    i_load,
  input  sample_t [FRAME-1:0]     i_frame_i,
  input  sample_t [FRAME-1:0]     i_frame_q,
  input  logic    [BEAT_W-1:0]    i_beat_sel,
  output sample_t [LANES-1:0]     o_beat_i,
  output sample_t [LANES-1:0]     o_beat_q
);

  // Storage is intentionally not reset; bank state lives in the parent.
  sample_t [FRAME-1:0] r_mem_i;
  sample_t [FRAME-1:0] r_mem_q;

  // Capture the whole frame in one edge on a load.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_mem_i <= i_frame_i;
      r_mem_q <= i_frame_q;
    end
  end

  // Lane l of beat k is sample k*LANES+l; LANES is a power of two so the address is a concatenation.
  always_comb begin
    o_beat_i = '0;
    o_beat_q = '0;
    for (int l = 0; l < LANES; l++) begin
      o_beat_i[l] = r_mem_i[{i_beat_sel, LANE_W'(l)}];
      o_beat_q[l] = r_mem_q[{i_beat_sel, LANE_W'(l)}];
    end
  end

endmodule

// File: rtl/frame_beat_tx.sv
// rtl/frame_beat_tx.sv - frame-to-beat transmitter; FRAME_TX_PINGPONG_EN selects two banks instead of one
module frame_beat_tx
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_load,
  input  sample_t [FRAME-1:0]     frame_i,
  input  sample_t [FRAME-1:0]     frame_q,
  output logic                    load_ready,
  output sample_t [LANES-1:0]     dout_i,
  output sample_t [LANES-1:0]     dout_q,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic    [BEAT_W-1:0]    beat_idx,
  output logic                    tx_done,
  output logic                    ovf_err
);

`ifdef FRAME_TX_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  bank_state_t          r_state [NB];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [BEAT_W-1:0]    r_beat_idx;
  logic                 r_tx_done;
  logic                 r_ovf;

  logic [NB-1:0]        w_is_rd;
  logic [NB-1:0]        w_is_wr;
  logic                 w_load_ready;
  logic                 w_accept;
  logic                 w_valid;
  logic                 w_hs;
  logic                 w_last_hs;
  sample_t [LANES-1:0]  w_bank_i [NB];
  sample_t [LANES-1:0]  w_bank_q [NB];
  sample_t [LANES-1:0]  w_sel_i;
  sample_t [LANES-1:0]  w_sel_q;

  // Decode pointers, readiness (registered states only) and the read-bank view.
  always_comb begin
    w_is_rd      = '0;
    w_is_wr      = '0;
    w_load_ready = 1'b0;
    w_valid      = 1'b0;
    w_sel_i      = '0;
    w_sel_q      = '0;
    for (int b = 0; b < NB; b++) begin
      w_is_rd[b] = (r_rd_ptr == 1'(b));
      w_is_wr[b] = (r_wr_ptr == 1'(b));
      if (r_state[b] == EMPTY) w_load_ready = 1'b1;
      if (w_is_rd[b]) begin
        // A FULL read bank already presents beat 0, giving one-cycle load latency.
        w_valid = (r_state[b] != EMPTY);
        w_sel_i = w_bank_i[b];
        w_sel_q = w_bank_q[b];
      end
    end
  end

  assign w_accept  = frame_load && w_load_ready;
  assign w_hs      = w_valid && dout_ready;
  assign w_last_hs = w_hs && is_last_beat(r_beat_idx);

  for (genvar gb = 0; gb < NB; gb++) begin : g_bank
    frame_bank u_bank (
      .clk        (clk),
      .i_load     (w_accept && w_is_wr[gb]),
      .i_frame_i  (frame_i),
      .i_frame_q  (frame_q),
      .i_beat_sel (r_beat_idx),
      .o_beat_i   (w_bank_i[gb]),
      .o_beat_q   (w_bank_q[gb])
    );
  end

  // Bank FSMs, pointers, beat counter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NB; b++) r_state[b] <= EMPTY;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_beat_idx <= '0;
      r_tx_done  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_tx_done <= w_last_hs;
      if (frame_load && !w_load_ready) r_ovf <= 1'b1;
      if (w_hs) r_beat_idx <= w_last_hs ? '0 : r_beat_idx + 1'b1;
      for (int b = 0; b < NB; b++) begin
        if (w_accept && w_is_wr[b]) begin
          r_state[b] <= FULL;
        end else if (w_is_rd[b]) begin
          if (w_last_hs)               r_state[b] <= EMPTY;
          else if (r_state[b] == FULL) r_state[b] <= SEND;
        end
      end
`ifdef FRAME_TX_PINGPONG_EN
      if (w_accept)  r_wr_ptr <= ~r_wr_ptr;
      if (w_last_hs) r_rd_ptr <= ~r_rd_ptr;
`endif
    end
  end

  assign load_ready = w_load_ready;
  assign dout_valid = w_valid;
  assign dout_i     = w_valid ? w_sel_i : '0;
  assign dout_q     = w_valid ? w_sel_q : '0;
  assign dout_last  = w_valid && is_last_beat(r_beat_idx);
  assign beat_idx   = r_beat_idx;
  assign tx_done    = r_tx_done;
  assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_frame_beat_tx.sv
// tb/tb_frame_beat_tx.sv - directed self-checking bench for frame_beat_tx (either bank build)
module tb_frame_beat_tx;
  import fft_pkg::*;

`ifdef FRAME_TX_PINGPONG_EN
  localparam int PP = 1;
`else
  localparam int PP = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 frame_load;
  sample_t [FRAME-1:0]  frame_i;
  sample_t [FRAME-1:0]  frame_q;
  logic                 load_ready;
  sample_t [LANES-1:0]  dout_i;
  sample_t [LANES-1:0]  dout_q;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 dout_last;
  logic [BEAT_W-1:0]    beat_idx;
  logic                 tx_done;
  logic                 ovf_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  frame_beat_tx dut (
    .clk        (clk),
    .rst        (rst),
    .frame_load (frame_load),
    .frame_i    (frame_i),
    .frame_q    (frame_q),
    .load_ready (load_ready),
    .dout_i     (dout_i),
    .dout_q     (dout_q),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .beat_idx   (beat_idx),
    .tx_done    (tx_done),
    .ovf_err    (ovf_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input int base);
    for (int n = 0; n < FRAME; n++) begin
      frame_i[n] = sample_t'(base + n);
      frame_q[n] = sample_t'(-(base + n));
    end
  endtask

  task automatic check_beat(input string tag, input int k, input int base);
    int bad;
    bad = 0;
    for (int l = 0; l < LANES; l++) begin
      if (dout_i[l] !== sample_t'(base + 32*k + l) ||
          dout_q[l] !== sample_t'(-(base + 32*k + l))) bad++;
    end
    chk({tag, " valid"}, int'(dout_valid), 1);
    chk({tag, " beat_idx"}, int'(beat_idx), k);
    chk({tag, " last"}, int'(dout_last), (k == BEATS-1) ? 1 : 0);
    chk({tag, " lane0 I"}, int'(dout_i[0]), base + 32*k);
    chk({tag, " bad lanes"}, bad, 0);
  endtask

  initial begin
    int k;
    int stall;

    rst        = 1'b1;
    frame_load = 1'b0;
    dout_ready = 1'b1;
    set_frame(0);
    tick();
    tick();

    chk("rst load_ready", int'(load_ready), 1);
    chk("rst valid", int'(dout_valid), 0);
    chk("rst last", int'(dout_last), 0);
    chk("rst beat_idx", int'(beat_idx), 0);
    chk("rst tx_done", int'(tx_done), 0);
    chk("rst ovf", int'(ovf_err), 0);
    chk("rst dout_i0", int'(dout_i[0]), 0);
    chk("rst dout_q31", int'(dout_q[31]), 0);
    rst = 1'b0;
    tick();

    // Basic frame, ready held high
    frame_load = 1'b1;
    tick();
    frame_load = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      check_beat("t1", b, 0);
      chk("t1 load_ready", int'(load_ready), PP);
      tick();
    end
    chk("t1 tx_done", int'(tx_done), 1);
    chk("t1 idle valid", int'(dout_valid), 0);
    chk("t1 idle dout_i0", int'(dout_i[0]), 0);
    tick();
    chk("t1 tx_done drop", int'(tx_done), 0);

    // Back-pressure on beats 3 and 15, two cycles each
    frame_load = 1'b1;
    tick();
    frame_load = 1'b0;
    k = 0;
    stall = 0;
    for (int c = 0; c < 20; c++) begin
      dout_ready = !((k == 3 || k == 15) && stall < 2);
      check_beat("t2", k, 0);
      tick();
      if (dout_ready) begin
        k++;
        stall = 0;
      end else begin
        stall++;
      end
    end
    dout_ready = 1'b1;
    chk("t2 tx_done", int'(tx_done), 1);
    chk("t2 valid", int'(dout_valid), 0);
    tick();

`ifndef FRAME_TX_PINGPONG_EN
    // Load while sending is rejected and flagged
    frame_load = 1'b1;
    tick();
    frame_load = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      if (b == 4) begin
        set_frame(2000);
        frame_load = 1'b1;
        chk("t3 load_ready", int'(load_ready), 0);
      end
      check_beat("t3", b, 0);
      tick();
      frame_load = 1'b0;
      set_frame(0);
      if (b == 4) chk("t3 ovf set", int'(ovf_err), 1);
    end
    chk("t3 tx_done", int'(tx_done), 1);
    chk("t3 ovf sticky", int'(ovf_err), 1);
    tick();
`endif

    // Reset at beat 7
    frame_load = 1'b1;
    tick();
    frame_load = 1'b0;
    for (int b = 0; b < 8; b++) begin
      check_beat("t4", b, 0);
      if (b < 7) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4 valid", int'(dout_valid), 0);
    chk("t4 beat_idx", int'(beat_idx), 0);
    chk("t4 load_ready", int'(load_ready), 1);
    chk("t4 tx_done", int'(tx_done), 0);
    chk("t4 ovf", int'(ovf_err), 0);
    chk("t4 dout_i0", int'(dout_i[0]), 0);
    tick();
    chk("t4 no tx_done", int'(tx_done), 0);
    set_frame(500);
    frame_load = 1'b1;
    tick();
    frame_load = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      check_beat("t4 new", b, 500);
      tick();
    end
    chk("t4 new tx_done", int'(tx_done), 1);
    tick();

    // Load at the last handshake with every bank occupied
    set_frame(0);
`ifdef FRAME_TX_PINGPONG_EN
    frame_load = 1'b1;
    tick();
    set_frame(1000);
    chk("t5 second bank ready", int'(load_ready), 1);
    check_beat("t5", 0, 0);
    tick();
    frame_load = 1'b0;
    for (int b = 1; b < 2*BEATS; b++) begin
      if (b == BEATS-1) begin
        set_frame(2000);
        frame_load = 1'b1;
        chk("t5 load_ready", int'(load_ready), 0);
      end
      check_beat("t5", b % BEATS, (b < BEATS) ? 0 : 1000);
      tick();
      frame_load = 1'b0;
      if (b == BEATS-1) begin
        chk("t5 mid tx_done", int'(tx_done), 1);
        chk("t5 ovf", int'(ovf_err), 1);
      end
    end
    chk("t5 end tx_done", int'(tx_done), 1);
    chk("t5 end valid", int'(dout_valid), 0);
`else
    frame_load = 1'b1;
    tick();
    frame_load = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      if (b == BEATS-1) begin
        set_frame(2000);
        frame_load = 1'b1;
        chk("t5 load_ready", int'(load_ready), 0);
      end
      check_beat("t5", b, 0);
      tick();
      frame_load = 1'b0;
    end
    chk("t5 ovf", int'(ovf_err), 1);
    chk("t5 tx_done", int'(tx_done), 1);
    chk("t5 valid", int'(dout_valid), 0);
    chk("t5 load_ready after", int'(load_ready), 1);
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
